// File: rtl/sdram_pkg.sv
// Shared types for the two-master SDRAM arbiter: FSM states, owner IDs and
// the latched request record.
package sdram_pkg;

   localparam int SDRAM_ADDR_W = 24;
   localparam int SDRAM_DATA_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT_RD = 2'd2
   } state_e;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_GPU = 1'b1
   } owner_e;

   typedef struct packed {
      logic                    we;
      logic [SDRAM_ADDR_W-1:0] addr;
      logic [SDRAM_DATA_W-1:0] wdata;
      logic [1:0]              dqm;
   } request_t;

endpackage

// File: rtl/sdram_arbiter.sv
// Two-master (CPU/GPU) front end for an SDRAM controller: GPU priority with a
// starvation escape for the CPU, one transaction outstanding at a time.
module sdram_arbiter
   import sdram_pkg::*;
#(
   parameter int ADDR_W       = 24,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_valid,
   output logic              cpu_ready,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic [1:0]        cpu_dqm,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              gpu_valid,
   output logic              gpu_ready,
   input  logic              gpu_we,
   input  logic [ADDR_W-1:0] gpu_addr,
   input  logic [DATA_W-1:0] gpu_wdata,
   input  logic [1:0]        gpu_dqm,
   output logic              gpu_rvalid,
   output logic [DATA_W-1:0] gpu_rdata,
   output logic              ctrl_valid,
   input  logic              ctrl_ready,
   output logic              ctrl_we,
   output logic [ADDR_W-1:0] ctrl_addr,
   output logic [DATA_W-1:0] ctrl_wdata,
   output logic [1:0]        ctrl_dqm,
   input  logic              ctrl_rvalid,
   input  logic [DATA_W-1:0] ctrl_rdata
);

   localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

   state_e            state_r;
   state_e            state_n_s;
   owner_e            owner_r;
   request_t          req_r;
   request_t          sel_req_s;
   logic [CNT_W-1:0]  starve_cnt_r;
   logic              grant_cpu_s;
   logic              grant_gpu_s;
   logic              accept_s;
   logic              ctrl_valid_r;
   logic              cpu_rvalid_r;
   logic              gpu_rvalid_r;
   logic [DATA_W-1:0] cpu_rdata_r;
   logic [DATA_W-1:0] gpu_rdata_r;

   // Winner selection in IDLE and mux of the winner's request fields
   always_comb begin
      grant_cpu_s = 1'b0;
      grant_gpu_s = 1'b0;
      sel_req_s   = '0;
      if ((state_r == ST_IDLE) && !reset) begin
         if (cpu_valid && (!gpu_valid || (starve_cnt_r == LIMIT_C))) begin
            grant_cpu_s = 1'b1;
         end else begin
            grant_gpu_s = gpu_valid;
         end
      end else begin
         grant_cpu_s = 1'b0;
         grant_gpu_s = 1'b0;
      end
      if (grant_cpu_s) begin
         sel_req_s.we    = cpu_we;
         sel_req_s.addr  = SDRAM_ADDR_W'(cpu_addr);
         sel_req_s.wdata = SDRAM_DATA_W'(cpu_wdata);
         sel_req_s.dqm   = cpu_dqm;
      end else begin
         sel_req_s.we    = gpu_we;
         sel_req_s.addr  = SDRAM_ADDR_W'(gpu_addr);
         sel_req_s.wdata = SDRAM_DATA_W'(gpu_wdata);
         sel_req_s.dqm   = gpu_dqm;
      end
   end

   assign accept_s = grant_cpu_s | grant_gpu_s;

   // Next-state decode
   always_comb begin
      state_n_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) state_n_s = ST_ISSUE;
            else          state_n_s = ST_IDLE;
         end
         ST_ISSUE: begin
            if (ctrl_ready) state_n_s = req_r.we ? ST_IDLE : ST_WAIT_RD;
            else            state_n_s = ST_ISSUE;
         end
         ST_WAIT_RD: begin
            if (ctrl_rvalid) state_n_s = ST_IDLE;
            else             state_n_s = ST_WAIT_RD;
         end
         default: state_n_s = ST_IDLE;
      endcase
   end

   // State, latched request, starvation counter and read-return registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         owner_r      <= OWN_CPU;
         req_r        <= '0;
         starve_cnt_r <= '0;
         ctrl_valid_r <= 1'b0;
         cpu_rvalid_r <= 1'b0;
         gpu_rvalid_r <= 1'b0;
         cpu_rdata_r  <= '0;
         gpu_rdata_r  <= '0;
      end else begin
         state_r      <= state_n_s;
         ctrl_valid_r <= (state_n_s == ST_ISSUE);
         cpu_rvalid_r <= 1'b0;
         gpu_rvalid_r <= 1'b0;
         if (accept_s) begin
            req_r   <= sel_req_s;
            owner_r <= grant_cpu_s ? OWN_CPU : OWN_GPU;
         end
         // Only GPU wins taken while the CPU is kept waiting count toward starvation
         if (grant_cpu_s) begin
            starve_cnt_r <= '0;
         end else if (grant_gpu_s && cpu_valid && (starve_cnt_r != LIMIT_C)) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
         end
         if ((state_r == ST_WAIT_RD) && ctrl_rvalid) begin
            if (owner_r == OWN_CPU) begin
               cpu_rvalid_r <= 1'b1;
               cpu_rdata_r  <= ctrl_rdata;
            end else begin
               gpu_rvalid_r <= 1'b1;
               gpu_rdata_r  <= ctrl_rdata;
            end
         end
      end
   end

   assign cpu_ready  = grant_cpu_s;
   assign gpu_ready  = grant_gpu_s;
   assign ctrl_valid = ctrl_valid_r;
   assign ctrl_we    = req_r.we;
   assign ctrl_addr  = ADDR_W'(req_r.addr);
   assign ctrl_wdata = DATA_W'(req_r.wdata);
   assign ctrl_dqm   = req_r.dqm;
   assign cpu_rvalid = cpu_rvalid_r;
   assign cpu_rdata  = cpu_rdata_r;
   assign gpu_rvalid = gpu_rvalid_r;
   assign gpu_rdata  = gpu_rdata_r;

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 24, word address width; DATA_W, default 16, data width; STARVE_LIMIT, default 4, number of consecutive GPU grants after which a waiting CPU wins.
REQ-002 SHALL have ports: clk input 1, the single clock; reset input 1, synchronous active-high reset.
REQ-003 SHALL have CPU port signals: cpu_valid in 1, request; cpu_ready out 1, accept; cpu_we in 1, write; cpu_addr in ADDR_W; cpu_wdata in DATA_W; cpu_dqm in 2, byte mask, active-high masks the byte; cpu_rvalid out 1, read data strobe; cpu_rdata out DATA_W.
REQ-004 SHALL have GPU port signals with the same set and widths, prefixed gpu_.
REQ-005 SHALL have controller-side signals: ctrl_valid out 1; ctrl_ready in 1; ctrl_we out 1; ctrl_addr out ADDR_W; ctrl_wdata out DATA_W; ctrl_dqm out 2; ctrl_rvalid in 1; ctrl_rdata in DATA_W.

Function
REQ-006 SHALL accept a master request only on the cycle that both its valid and ready signals are high; ready SHALL be high only in IDLE and only for the granted master.
REQ-007 SHALL implement the states IDLE, ISSUE and WAIT_RD; no other states SHALL be reachable.
REQ-008 IDLE: if any valid is high, SHALL select the winner combinationally, assert that master's ready, latch we/addr/wdata/dqm and the owner ID, and go to ISSUE on the next cycle.
REQ-009 Arbitration: GPU SHALL win over CPU unless starve_cnt equals STARVE_LIMIT and cpu_valid is high, in which case CPU SHALL win.
REQ-010 starve_cnt SHALL increment (saturating at STARVE_LIMIT) on each GPU grant while cpu_valid is high, and SHALL clear on any CPU grant.
REQ-011 ISSUE: ctrl_valid SHALL be held high with the latched fields stable until ctrl_ready is high; after that handshake, writes SHALL return to IDLE and reads SHALL go to WAIT_RD.
REQ-012 WAIT_RD: on ctrl_rvalid, SHALL drive ctrl_rdata to the owner's rdata and pulse that owner's rvalid for exactly one cycle (registered, 1 cycle after ctrl_rvalid), then return to IDLE.
REQ-013 Only one transaction SHALL be outstanding; neither ready SHALL be asserted outside IDLE.
REQ-014 The non-owner's rvalid SHALL stay low at all times; a ctrl_rvalid received outside WAIT_RD SHALL be ignored.
REQ-015 When both valids rise in the same cycle with starve_cnt < STARVE_LIMIT, GPU SHALL be granted, and CPU SHALL remain waiting without losing its request.
REQ-016 The minimum accept-to-accept spacing for writes with ctrl_ready tied high SHALL be 2 cycles: IDLE, ISSUE, then IDLE again.

Reset
REQ-017 While reset is high on a clock edge, the state SHALL become IDLE; starve_cnt, ctrl_valid, cpu_ready, gpu_ready, cpu_rvalid and gpu_rvalid SHALL be 0; the latched fields and rdata SHALL be 0.
REQ-018 A reset asserted mid-transaction SHALL abandon the transaction; no rvalid SHALL be produced for that transaction after reset is released.

Structure
REQ-019 The state enum, the owner enum (OWN_CPU, OWN_GPU) and the request struct (we, addr, wdata, dqm) SHALL live in the shared package sdram_pkg.
REQ-020 SHALL be a single module with no sub-modules; the priority/starvation logic is small enough to be kept inline.

Verification
REQ-021 CPU-only read at 0x000010, controller returns 0xBEEF 3 cycles after acceptance -> cpu_rvalid pulses once with 0xBEEF, and gpu_rvalid stays 0.
REQ-022 Both masters write in the same cycle (CPU addr 0x5, GPU addr 0x6), ctrl_ready=1 -> GPU issued first, CPU issued 2 cycles later, and ctrl_addr sequence is 6 then 5.
REQ-023 GPU valid held high continuously, CPU valid high, STARVE_LIMIT=4 -> exactly 4 GPU grants, then a CPU grant, then starve_cnt=0.
REQ-024 ctrl_ready held low for 10 cycles during ISSUE -> ctrl_valid/addr/wdata/dqm stable for all 10 cycles and no new ready asserted.
REQ-025 Reset asserted in WAIT_RD, then ctrl_rvalid pulses after release -> no rvalid on either port and state is IDLE.
REQ-026 Masked write with cpu_dqm=2'b10 and data 0x1234 -> ctrl_dqm=2'b10 and ctrl_wdata=0x1234 on the ctrl handshake cycle.
